fir_dec_sink: RTL and testbench

//  Output-side counterpart of the 17-tap FIR filter. Accepts the filter's 10-bit signed

---
 rtl/fir_pkg.sv | 5 +
 rtl/fir_dec_sink_if.sv | 26 ++
 rtl/fir_sync_fifo.sv | 51 +++++
 rtl/fir_dec_sink.sv | 76 +++++++
 tb/tb_fir_dec_sink.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared FIR datapath types: sample width and the signed sample type used by the FIR core and its sinks.
package fir_pkg;
   localparam int FIR_DATA_W = 10;
   typedef logic signed [FIR_DATA_W-1:0] fir_sample_t;
endpackage

// File: rtl/fir_dec_sink_if.sv
// Stream-in / valid-ready-out bundle of the FIR decimating sink; slave is the sink's view.
interface fir_dec_sink_if #(
   parameter int DATA_W     = fir_pkg::FIR_DATA_W,
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic signed [DATA_W-1:0] data_i;
   logic                     valid_i;
   logic                     phase_clr_i;
   logic signed [DATA_W-1:0] data_o;
   logic                     valid_o;
   logic                     ready_i;
   logic [LVL_W-1:0]         level_o;
   logic                     overflow_o;

   modport master (
      output data_i, valid_i, phase_clr_i, ready_i,
      input  data_o, valid_o, level_o, overflow_o
   );

   modport slave (
      input  data_i, valid_i, phase_clr_i, ready_i,
      output data_o, valid_o, level_o, overflow_o
   );
endinterface

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO, wrap pointers with extra bit; head visible combinationally, last popped value held when empty.
// Push while full succeeds only alongside a pop; otherwise it is ignored and content is untouched.
module fir_sync_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_dat,
   input  logic             pop,
   output logic [W-1:0]     head_dat,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] last_dat;
   logic         wr_en;
   logic         rd_en;

   assign level    = wr_ptr - rd_ptr;
   assign full     = (level == LVL_W'(DEPTH));
   assign empty    = (wr_ptr == rd_ptr);
   assign rd_en    = pop && !empty;
   assign wr_en    = push && (!full || rd_en);
   assign head_dat = empty ? last_dat : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         last_dat <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) begin
            rd_ptr   <= rd_ptr + 1'b1;
            last_dat <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // On full+pop the write lands in the slot being vacated this same edge.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

// File: rtl/fir_dec_sink.sv
// Decimate-by-2**DEC_LOG2 sink behind the FIR; result visible 1 clk after the M-th sample; input never stalls,
// full FIFO without a same-cycle pop drops the result and sets sticky overflow. FIR_DEC_AVG_EN selects averaging.
module fir_dec_sink
   import fir_pkg::*;
#(
   parameter int DATA_W     = FIR_DATA_W,
   parameter int DEC_LOG2   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   fir_dec_sink_if.slave bus
);
   logic [DEC_LOG2-1:0]      phase;
   logic [DEC_LOG2-1:0]      phase_eff;
   logic                     dec_vld;
   logic signed [DATA_W-1:0] dec_dat;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     pop;
   logic                     overflow;

   // A clear in the same cycle as a sample makes that sample phase 0.
   assign phase_eff = bus.phase_clr_i ? '0 : phase;
   assign dec_vld   = bus.valid_i && (phase_eff == '1);
   assign pop       = bus.ready_i && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst)                  phase <= '0;
      else if (bus.valid_i)     phase <= phase_eff + 1'b1;
      else if (bus.phase_clr_i) phase <= '0;
   end

`ifdef FIR_DEC_AVG_EN
   localparam int ACC_W = DATA_W + DEC_LOG2;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] data_ext;
   logic signed [ACC_W-1:0] sum_nxt;

   assign data_ext = {{DEC_LOG2{bus.data_i[DATA_W-1]}}, bus.data_i};
   assign sum_nxt  = (phase_eff == '0) ? data_ext : acc + data_ext;
   // Dropping the low bits of the sum is the floor-rounded arithmetic divide by M.
   assign dec_dat  = sum_nxt[ACC_W-1:DEC_LOG2];

   always_ff @(posedge clk) begin
      if (rst)                  acc <= '0;
      else if (bus.valid_i)     acc <= sum_nxt;
      else if (bus.phase_clr_i) acc <= '0;
   end
`else
   assign dec_dat = bus.data_i;
`endif

   always_ff @(posedge clk) begin
      if (rst)                                  overflow <= 1'b0;
      else if (dec_vld && fifo_full && !pop)    overflow <= 1'b1;
   end

   fir_sync_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (dec_vld),
      .push_dat (dec_dat),
      .pop      (pop),
      .head_dat (bus.data_o),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (bus.level_o)
   );

   assign bus.valid_o    = !fifo_empty;
   assign bus.overflow_o = overflow;
endmodule

// File: tb/tb_fir_dec_sink.sv
// Bench for fir_dec_sink: directed scenarios plus random traffic against a group/queue reference model.
module tb_fir_dec_sink;
   import fir_pkg::*;

   localparam int M     = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fir_dec_sink_if #(.DATA_W(FIR_DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

   fir_dec_sink #(.DATA_W(FIR_DATA_W), .DEC_LOG2(2), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: samples of the open group, pending results, last consumed value, sticky drop flag.
   int          grp[$];
   fir_sample_t exp_q[$];
   fir_sample_t exp_last;
   bit          exp_ovf;

   function automatic fir_sample_t group_result();
`ifdef FIR_DEC_AVG_EN
      int sum = 0;
      int q;
      foreach (grp[k]) sum += grp[k];
      q = sum / M;
      if ((sum % M) != 0 && sum < 0) q -= 1;
      return fir_sample_t'(q);
`else
      return fir_sample_t'(grp[M-1]);
`endif
   endfunction

   function automatic fir_sample_t exp_data();
      return (exp_q.size() != 0) ? exp_q[0] : exp_last;
   endfunction

   function automatic int rnd_sample();
      return int'($urandom_range(0, 1023)) - 512;
   endfunction

   task automatic step(input bit v, input int d, input bit clr, input bit rdy);
      bit pop;
      bus.valid_i     = v;
      bus.data_i      = fir_sample_t'(d);
      bus.phase_clr_i = clr;
      bus.ready_i     = rdy;
      pop = rdy && (exp_q.size() != 0);
      if (clr) grp.delete();
      if (v) grp.push_back(int'(fir_sample_t'(d)));
      if (pop) exp_last = exp_q.pop_front();
      if (grp.size() == M) begin
         fir_sample_t r = group_result();
         grp.delete();
         if (exp_q.size() < DEPTH) exp_q.push_back(r);
         else exp_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.valid_i     = 1'b0;
      bus.data_i      = '0;
      bus.phase_clr_i = 1'b0;
      bus.ready_i     = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      grp.delete();
      exp_q.delete();
      exp_last = '0;
      exp_ovf  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total += 4;
      if (bus.data_o !== '0) $display("FAIL reset_data got %0d want 0", bus.data_o); else passed++;
      if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid_o); else passed++;
      if (bus.level_o !== '0) $display("FAIL reset_level got %0d want 0", bus.level_o); else passed++;
      if (bus.overflow_o !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow_o); else passed++;
   endtask

   task automatic test_basic();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, i, 1'b0, 1'b1);
         total++;
         if (bus.valid_o !== ((i == 4) || (i == 8)))
            $display("FAIL basic_valid s%0d got %b want %b", i, bus.valid_o, (i == 4) || (i == 8));
         else passed++;
         if ((i == 4) || (i == 8)) begin
            total++;
            if (bus.data_o !== exp_data()) $display("FAIL basic_data s%0d got %0d want %0d", i, bus.data_o, exp_data());
            else passed++;
         end
      end
      step(1'b0, 0, 1'b0, 1'b1);
      total += 2;
      if (bus.valid_o !== 1'b0) $display("FAIL basic_drain valid got %b want 0", bus.valid_o); else passed++;
      if (bus.data_o !== exp_data()) $display("FAIL basic_hold got %0d want %0d", bus.data_o, exp_data()); else passed++;
   endtask

   task automatic test_avg();
`ifdef FIR_DEC_AVG_EN
      int vec[12] = '{10, 20, 30, 41, -1, -1, -1, -2, -512, -512, -512, -512};
      int want[3] = '{25, -2, -512};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b1, vec[i], 1'b0, 1'b1);
         if ((i % 4) == 3) begin
            total++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== fir_sample_t'(want[i/4]))
               $display("FAIL avg_result g%0d got %0d (vld %b) want %0d", i / 4, bus.data_o, bus.valid_o, want[i/4]);
            else passed++;
         end
      end
`endif
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, rnd_sample(), 1'b0, 1'b0);
         if (i == 16) begin
            total += 2;
            if (bus.level_o !== 3'd4) $display("FAIL ovf_full_level got %0d want 4", bus.level_o); else passed++;
            if (bus.overflow_o !== 1'b0) $display("FAIL ovf_early got %b want 0", bus.overflow_o); else passed++;
         end
      end
      total += 2;
      if (bus.level_o !== 3'd4) $display("FAIL ovf_level got %0d want 4", bus.level_o); else passed++;
      if (bus.overflow_o !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.overflow_o); else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (bus.data_o !== exp_data()) $display("FAIL ovf_drain r%0d got %0d want %0d", k, bus.data_o, exp_data());
         else passed++;
         step(1'b0, 0, 1'b0, 1'b1);
      end
      total += 2;
      if (bus.level_o !== 3'd0) $display("FAIL ovf_empty got %0d want 0", bus.level_o); else passed++;
      if (bus.overflow_o !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.overflow_o); else passed++;
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 19; i++) step(1'b1, rnd_sample(), 1'b0, 1'b0);
      step(1'b1, rnd_sample(), 1'b0, 1'b1);
      total += 2;
      if (bus.overflow_o !== 1'b0) $display("FAIL fullpop_ovf got %b want 0", bus.overflow_o); else passed++;
      if (bus.level_o !== 3'd4) $display("FAIL fullpop_level got %0d want 4", bus.level_o); else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (bus.data_o !== exp_data()) $display("FAIL fullpop_drain r%0d got %0d want %0d", k, bus.data_o, exp_data());
         else passed++;
         step(1'b0, 0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_phase_clr();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, rnd_sample(), i == 2, 1'b1);
         total++;
         if (bus.valid_o !== (i == 5)) $display("FAIL clr_valid s%0d got %b want %b", i, bus.valid_o, i == 5);
         else passed++;
      end
      total++;
      if (bus.data_o !== exp_data()) $display("FAIL clr_data got %0d want %0d", bus.data_o, exp_data()); else passed++;
   endtask

   task automatic test_rst_mid();
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, rnd_sample(), 1'b0, 1'b0);
      total++;
      if (bus.level_o !== 3'd2) $display("FAIL rstmid_pre_level got %0d want 2", bus.level_o); else passed++;
      do_reset();
      total += 4;
      if (bus.data_o !== '0) $display("FAIL rstmid_data got %0d want 0", bus.data_o); else passed++;
      if (bus.valid_o !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus.valid_o); else passed++;
      if (bus.level_o !== '0) $display("FAIL rstmid_level got %0d want 0", bus.level_o); else passed++;
      if (bus.overflow_o !== 1'b0) $display("FAIL rstmid_ovf got %b want 0", bus.overflow_o); else passed++;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, rnd_sample(), 1'b0, 1'b1);
         total++;
         if (bus.valid_o !== (i == 3)) $display("FAIL rstmid_valid s%0d got %b want %b", i, bus.valid_o, i == 3);
         else passed++;
      end
      total++;
      if (bus.data_o !== exp_data()) $display("FAIL rstmid_result got %0d want %0d", bus.data_o, exp_data()); else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit rdy = (i < 200) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 3) != 0, rnd_sample(), $urandom_range(0, 19) == 0, rdy);
         total += 4;
         if (bus.valid_o !== (exp_q.size() != 0))
            $display("FAIL rand_valid c%0d got %b want %b", i, bus.valid_o, exp_q.size() != 0);
         else passed++;
         if (bus.data_o !== exp_data()) $display("FAIL rand_data c%0d got %0d want %0d", i, bus.data_o, exp_data());
         else passed++;
         if (bus.level_o !== 3'(exp_q.size()))
            $display("FAIL rand_level c%0d got %0d want %0d", i, bus.level_o, exp_q.size());
         else passed++;
         if (bus.overflow_o !== exp_ovf) $display("FAIL rand_ovf c%0d got %b want %b", i, bus.overflow_o, exp_ovf);
         else passed++;
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.valid_i     = 1'b0;
      bus.data_i      = '0;
      bus.phase_clr_i = 1'b0;
      bus.ready_i     = 1'b0;
      test_reset();
      test_basic();
      test_avg();
      test_overflow();
      test_full_pop();
      test_phase_clr();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
